// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron layer scheduler.
// Holds default widths, FSM encoding and a signed compare helper.
package nn_pkg;

  localparam int NN_ACC_W       = 26;
  localparam int NN_IDX_W       = 4;
  localparam int NN_NUM_NEURONS = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  function automatic logic sgt(
    input logic signed [63:0] a,
    input logic signed [63:0] b
  );
    return a > b;
  endfunction

endpackage

// File: rtl/neuron_layer_scheduler_if.sv
// Per-neuron result stream (valid/ready) out of the layer scheduler.
// Master drives the result, slave returns ready.
interface neuron_layer_scheduler_if
  import nn_pkg::*;
#(
  parameter int ACC_W = NN_ACC_W,
  parameter int IDX_W = NN_IDX_W
) ();

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [IDX_W-1:0] res_idx;

  modport master (
    output res_valid,
    output res_data,
    output res_idx,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_idx,
    output res_ready
  );

endinterface

// File: rtl/argmax_tracker.sv
// Running signed argmax over one layer pass.
// First load after clear is unconditional; later loads need strictly greater.
module argmax_tracker
  import nn_pkg::*;
#(
  parameter int ACC_W = NN_ACC_W,
  parameter int IDX_W = NN_IDX_W
) (
  input  logic             clk,
  input  logic             GlobalReset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  input  logic [ACC_W-1:0] value,
  output logic [IDX_W-1:0] best_idx,
  output logic [ACC_W-1:0] best_val
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] val_q, val_d;
  logic             better;

  assign better = sgt(64'($signed(value)), 64'($signed(val_q)));

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    val_d   = val_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load && (!valid_q || better)) begin
      valid_d = 1'b1;
      idx_d   = idx;
      val_d   = value;
    end
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
    end
  end

  assign best_idx = idx_q;
  assign best_val = val_q;

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Steps one shared Neuron MAC through every output neuron of a layer,
// streams each result out and reports the signed argmax class.
module neuron_layer_scheduler
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = NN_NUM_NEURONS,
  parameter int IDX_W       = NN_IDX_W,
  parameter int ACC_W       = NN_ACC_W,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     GlobalReset_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic [IDX_W-1:0]         neuron_idx,
  output logic                     nrn_input_valid,
  input  logic [ACC_W-1:0]         nrn_out,
  input  logic                     nrn_output_valid,
  neuron_layer_scheduler_if.master res,
  output logic                     done,
  output logic [IDX_W-1:0]         class_idx,
  output logic [ACC_W-1:0]         class_score,
  output logic                     error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             busy_q, busy_d;
  logic             iv_q, iv_d;
  logic             rv_q, rv_d;
  logic [ACC_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] ri_q, ri_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             am_clear, am_load;
  logic             rise;

  assign rise = nrn_output_valid & ~prev_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    prev_d   = nrn_output_valid;
    busy_d   = busy_q;
    iv_d     = 1'b0;
    rv_d     = rv_q;
    rd_d     = rd_q;
    ri_d     = ri_q;
    done_d   = 1'b0;
    err_d    = err_q;
    am_clear = 1'b0;
    am_load  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      rv_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_ISSUE;
            idx_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            iv_d     = 1'b1;
            err_d    = 1'b0;
            am_clear = 1'b1;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          // A result edge in the last waiting cycle still wins over timeout
          if (rise) begin
            state_d = S_OUT;
            rv_d    = 1'b1;
            rd_d    = nrn_out;
            ri_d    = idx_q;
            am_load = 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
        S_OUT: begin
          if (res.res_ready) begin
            rv_d = 1'b0;
            if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              state_d = S_ISSUE;
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = '0;
              iv_d    = 1'b1;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rv_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      busy_q  <= 1'b0;
      iv_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      ri_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      iv_q    <= iv_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      ri_q    <= ri_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  argmax_tracker #(
    .ACC_W(ACC_W),
    .IDX_W(IDX_W)
  ) u_argmax (
    .clk          (clk),
    .GlobalReset_n(GlobalReset_n),
    .clear        (am_clear),
    .load         (am_load),
    .idx          (idx_q),
    .value        (nrn_out),
    .best_idx     (class_idx),
    .best_val     (class_score)
  );

  assign busy            = busy_q;
  assign neuron_idx      = idx_q;
  assign nrn_input_valid = iv_q;
  assign res.res_valid   = rv_q;
  assign res.res_data    = rd_q;
  assign res.res_idx     = ri_q;
  assign done            = done_q;
  assign error           = err_q;

endmodule
